combinational_mux_14bit_output: RTL and testbench
=================================================

Name: combinational_mux_14bit_output

Overview:
- Display-source selector for the step-tracker datapath.
- Picks one of four 14-bit activity statistics by a 3-bit mode code and registers it for the 4-digit seven-segment display path.
- Also provides a clamped binary value, a BCD image and status flags.
- Sits between the step counter/statistics blocks and the display driver.

Parameters:
- DATA_W, 14, width of each statistic input and of the binary output.
- MAX_DISPLAY, 9999, largest value representable on the 4-digit display; output clamp limit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  3  source select code.
- total_steps  input  DATA_W  accumulated step count.
- distance_covered  input  DATA_W  distance statistic.
- thirty_two_steps_per_second  input  DATA_W  count of seconds exceeding 32 steps/s.
- sixty_four_steps_per_second  input  DATA_W  count of seconds exceeding 64 steps/s.
- main_output  output  DATA_W  selected, clamped value (registered).
- main_output_bcd  output  16  four BCD digits of main_output; [15:12] thousands … [3:0] units (registered).
- mode_valid  output  1  1 when the registered mode was 0–3.
- over_range  output  1  1 when the selected raw value exceeded MAX_DISPLAY.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: on a clk edge with reset=1, main_output=0, main_output_bcd=16'h0000, mode_valid=0, over_range=0. Reset has priority over all inputs. Asserting reset mid-operation clears all outputs on that edge.
- Selection:
  - mode 0 → total_steps
  - mode 1 → distance_covered
  - mode 2 → thirty_two_steps_per_second
  - mode 3 → sixty_four_steps_per_second
  - mode 4–7 → selected value 0, mode_valid=0
- Clamp: if the selected raw value > MAX_DISPLAY, main_output=MAX_DISPLAY and over_range=1; otherwise the value passes unchanged and over_range=0. A value equal to MAX_DISPLAY is not over range.
- BCD: main_output_bcd is the exact decimal of the clamped value. Conversion is combinational (double-dabble) ahead of the output register, so the BCD never lags main_output.
- Latency: exactly 1 clk. All outputs reflect mode/data sampled at the previous rising edge.
- Outputs are held constant while inputs are constant.
- No handshake; inputs are sampled every cycle.
- A mode change and a data change in the same cycle: the new mode selects the new data on the same edge.

Decomposition:
- Shared package holds:
  - mode code constants: MODE_TOTAL_STEPS=0, MODE_DISTANCE=1, MODE_32SPS=2, MODE_64SPS=3
  - DATA_W and MAX_DISPLAY defaults
- One sub-module, bin_to_bcd_14: purely combinational, 14-bit binary in, 16-bit BCD out, valid for inputs 0–9999.
- Mux, clamp and output register stay in the top module.

Test Plan:
- Inputs total_steps=1234, distance_covered=567, thirty_two_steps_per_second=45, sixty_four_steps_per_second=128, with mode stepped 0→1→2→3→0, each held 10 cycles:
  - main_output = 1234, 567, 45, 128, 1234, each one cycle after the mode change
  - main_output_bcd = 16'h1234, 16'h0567, 16'h0045, 16'h0128
  - mode_valid=1 and over_range=0 throughout
- mode=5 with the same inputs → main_output=0, main_output_bcd=16'h0000, mode_valid=0, over_range=0.
- mode=0:
  - total_steps=12000 → main_output=9999, main_output_bcd=16'h9999, over_range=1
  - then total_steps=9999 → over_range=0, main_output=9999
- mode=1, distance_covered changes from 567 to 568 on the same edge as mode changes from 0 to 1 → next-cycle main_output=568.
- reset=1 for one cycle while mode=0, total_steps=1234 → all outputs 0 on that edge; main_output returns to 1234 one cycle after reset deasserts.
- Power-on: reset held 3 cycles with arbitrary inputs → outputs stay 0 during all 3 cycles.

Source files
------------

// File: rtl/combinational_mux_14bit_output_pkg.sv
// rtl/combinational_mux_14bit_output_pkg.sv - shared constants for the display-source selector
package combinational_mux_14bit_output_pkg;

    localparam int DEF_DATA_W      = 14;
    localparam int DEF_MAX_DISPLAY = 9999;

    localparam logic [2:0] MODE_TOTAL_STEPS = 3'd0;
    localparam logic [2:0] MODE_DISTANCE    = 3'd1;
    localparam logic [2:0] MODE_32SPS       = 3'd2;
    localparam logic [2:0] MODE_64SPS       = 3'd3;

endpackage

// File: rtl/combinational_mux_14bit_output_if.sv
// rtl/combinational_mux_14bit_output_if.sv - statistics/mode inputs and display outputs of the selector
interface combinational_mux_14bit_output_if
    import combinational_mux_14bit_output_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [2:0]        mode;
    logic [DATA_W-1:0] total_steps;
    logic [DATA_W-1:0] distance_covered;
    logic [DATA_W-1:0] thirty_two_steps_per_second;
    logic [DATA_W-1:0] sixty_four_steps_per_second;
    logic [DATA_W-1:0] main_output;
    logic [15:0]       main_output_bcd;
    logic              mode_valid;
    logic              over_range;

    modport master (
        output mode, total_steps, distance_covered,
               thirty_two_steps_per_second, sixty_four_steps_per_second,
        input  main_output, main_output_bcd, mode_valid, over_range
    );

    modport slave (
        input  mode, total_steps, distance_covered,
               thirty_two_steps_per_second, sixty_four_steps_per_second,
        output main_output, main_output_bcd, mode_valid, over_range
    );

endinterface

// File: rtl/combinational_mux_14bit_output_bin_to_bcd_14.sv
// rtl/combinational_mux_14bit_output_bin_to_bcd_14.sv - combinational 14-bit binary to 4-digit BCD
module bin_to_bcd_14 (
    input  logic [13:0] bin_i,
    output logic [15:0] bcd_o
);

    // Double-dabble: BCD digits live in sr[29:14], binary shifts out of sr[13:0].
    logic [29:0] sr;

    always_comb begin
        sr = '0;
        sr[13:0] = bin_i;
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sr[14+4*d +: 4] >= 4'd5) begin
                    sr[14+4*d +: 4] = sr[14+4*d +: 4] + 4'd3;
                end
            end
            sr = sr << 1;
        end
        bcd_o = sr[29:14];
    end

endmodule

// File: rtl/combinational_mux_14bit_output.sv
// rtl/combinational_mux_14bit_output.sv - selects, clamps and registers one activity statistic for display
module combinational_mux_14bit_output
    import combinational_mux_14bit_output_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_DISPLAY = DEF_MAX_DISPLAY
) (
    input  logic                             clk,
    input  logic                             reset,
    combinational_mux_14bit_output_if.slave  bus
);

    localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(MAX_DISPLAY);

    logic [DATA_W-1:0] raw;
    logic              mode_ok;
    logic [DATA_W-1:0] main_output_d, main_output_q;
    logic [15:0]       bcd_d, bcd_q;
    logic              mode_valid_d, mode_valid_q;
    logic              over_range_d, over_range_q;

    always_comb begin
        raw     = '0;
        mode_ok = 1'b1;
        case (bus.mode)
            MODE_TOTAL_STEPS: raw = bus.total_steps;
            MODE_DISTANCE:    raw = bus.distance_covered;
            MODE_32SPS:       raw = bus.thirty_two_steps_per_second;
            MODE_64SPS:       raw = bus.sixty_four_steps_per_second;
            default:          mode_ok = 1'b0;
        endcase
    end

    always_comb begin
        over_range_d  = raw > MAX_VAL;
        main_output_d = over_range_d ? MAX_VAL : raw;
        mode_valid_d  = mode_ok;
    end

    // BCD is derived from the clamped value before the register so both update together.
    bin_to_bcd_14 u_bcd (
        .bin_i (main_output_d),
        .bcd_o (bcd_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            main_output_q <= '0;
            bcd_q         <= '0;
            mode_valid_q  <= 1'b0;
            over_range_q  <= 1'b0;
        end else begin
            main_output_q <= main_output_d;
            bcd_q         <= bcd_d;
            mode_valid_q  <= mode_valid_d;
            over_range_q  <= over_range_d;
        end
    end

    assign bus.main_output     = main_output_q;
    assign bus.main_output_bcd = bcd_q;
    assign bus.mode_valid      = mode_valid_q;
    assign bus.over_range      = over_range_q;

endmodule

// File: tb/tb_combinational_mux_14bit_output.sv
// tb/tb_combinational_mux_14bit_output.sv - directed self-checking bench for the display-source selector
module tb_combinational_mux_14bit_output;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    combinational_mux_14bit_output_if #(.DATA_W(14)) bus ();

    combinational_mux_14bit_output dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int val, input logic [15:0] bcd,
                             input logic valid, input logic over);
        check_eq({tag, ".main_output"}, 32'(bus.main_output), 32'(val));
        check_eq({tag, ".bcd"},         32'(bus.main_output_bcd), 32'(bcd));
        check_eq({tag, ".mode_valid"},  32'(bus.mode_valid), 32'(valid));
        check_eq({tag, ".over_range"},  32'(bus.over_range), 32'(over));
    endtask

    task automatic set_stats(input int ts, input int dc, input int s32, input int s64);
        bus.total_steps                 = 14'(ts);
        bus.distance_covered            = 14'(dc);
        bus.thirty_two_steps_per_second = 14'(s32);
        bus.sixty_four_steps_per_second = 14'(s64);
    endtask

    int          exp_val [5] = '{1234, 567, 45, 128, 1234};
    logic [15:0] exp_bcd [5] = '{16'h1234, 16'h0567, 16'h0045, 16'h0128, 16'h1234};
    logic [2:0]  modes   [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

    initial begin
        reset    = 1'b1;
        bus.mode = 3'd2;
        set_stats(500, 9000, 16383, 77);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("por%0d", i), 0, 16'h0000, 1'b0, 1'b0);
            bus.mode = 3'(i);
        end

        reset = 1'b0;
        set_stats(1234, 567, 45, 128);
        for (int m = 0; m < 5; m++) begin
            bus.mode = modes[m];
            tick();
            check_all($sformatf("mode_step%0d_first", m), exp_val[m], exp_bcd[m], 1'b1, 1'b0);
            for (int c = 1; c < 10; c++) tick();
            check_all($sformatf("mode_step%0d_held", m), exp_val[m], exp_bcd[m], 1'b1, 1'b0);
        end

        bus.mode = 3'd5;
        tick();
        check_all("mode5", 0, 16'h0000, 1'b0, 1'b0);
        bus.mode = 3'd7;
        tick();
        check_all("mode7", 0, 16'h0000, 1'b0, 1'b0);

        bus.mode = 3'd0;
        bus.total_steps = 14'd12000;
        tick();
        check_all("clamp12000", 9999, 16'h9999, 1'b1, 1'b1);
        bus.total_steps = 14'd9999;
        tick();
        check_all("exact9999", 9999, 16'h9999, 1'b1, 1'b0);
        bus.total_steps = 14'd10000;
        tick();
        check_all("clamp10000", 9999, 16'h9999, 1'b1, 1'b1);
        bus.total_steps = 14'd0;
        tick();
        check_all("zero", 0, 16'h0000, 1'b1, 1'b0);

        bus.total_steps = 14'd1234;
        bus.distance_covered = 14'd567;
        tick();
        check_all("pre_same_edge", 1234, 16'h1234, 1'b1, 1'b0);
        bus.mode = 3'd1;
        bus.distance_covered = 14'd568;
        tick();
        check_all("same_edge", 568, 16'h0568, 1'b1, 1'b0);

        bus.mode = 3'd0;
        reset = 1'b1;
        tick();
        check_all("mid_reset", 0, 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_all("post_reset", 1234, 16'h1234, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
